// File: rtl/uart_rx_pl.sv
// rtl/uart_rx_pl.sv - 8N1 UART receiver with one-entry holding register
//
// Purpose: receive 8N1 bytes from an asynchronous serial line, present them
// through a single holding register with a valid/ready handshake, and flag
// framing errors and dropped bytes.
//
// Ports:
//   clk100      in   clock
//   rstn        in   asynchronous active-low reset
//   rx_i        in   serial line, asynchronous, idles high
//   data_o      out  [7:0] received byte, LSB first on the wire
//   valid_o     out  data_o holds an unconsumed byte
//   ready_i     in   consumer accepts data_o when valid_o & ready_i
//   frame_err_o out  one-cycle pulse on a low stop bit
//   overrun_o   out  sticky: a good byte was dropped, slot was full
//   clr_i       in   synchronous clear of overrun_o
module uart_rx_pl #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200
) (
  input  logic       clk100,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_i
);

  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_baud
      $error("uart_rx_pl: CLKS_PER_BIT must be at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  // Set after a low stop bit: STOP then only waits for the line to go high,
  // so a long break yields a single framing-error pulse.
  logic             brk_q, brk_d;
  logic             rx_meta_q, rx_s_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    brk_d   = brk_q;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // Clear first so a same-cycle overrun below takes priority.
    if (clr_i) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // High at mid start bit means the falling edge was a glitch.
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (brk_q) begin
          cnt_d = '0;
          if (rx_s_q) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Leaving at mid stop bit keeps half a bit of margin for a
            // start bit that directly follows.
            state_d = ST_IDLE;
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_pl.sv
// tb/tb_uart_rx_pl.sv - self-checking bench for uart_rx_pl
module tb_uart_rx_pl;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIT_T  = 16;

  logic       clk100 = 1'b0;
  logic       rstn;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       clr_i;

  uart_rx_pl #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk100     (clk100),
    .rstn       (rstn),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .clr_i      (clr_i)
  );

  always #5 clk100 = ~clk100;

  int n_pass = 0;
  int n_total = 0;
  int ferr_cnt = 0;
  int vrise_cnt = 0;
  int hs_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low_bits;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Observe this cycle's outputs (stable since the last edge + 1), then advance.
  task automatic tick();
    if (valid_o && ready_i) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_byte", {24'd0, data_o}, 32'hFFFF_FFFF);
      else chk("sb_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
    end
    if (frame_err_o) ferr_cnt++;
    if (valid_o && !valid_prev) vrise_cnt++;
    valid_prev = valid_o;
    @(posedge clk100);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx_i = 1'b0;
    ticks(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      ticks(BIT_T);
    end
    rx_i = stop;
    ticks(BIT_T);
    rx_i = 1'b1;
  endtask

  task automatic consume(input string name);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    tick();
    chk(name, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int f0, v0, h0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, hold_low_bits: 0,  exp_valid: 1'b1, exp_ferr: 0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, hold_low_bits: 40, exp_valid: 1'b0, exp_ferr: 1};
    vecs[2] = '{data: 8'h3C, stop: 1'b1, hold_low_bits: 0,  exp_valid: 1'b1, exp_ferr: 0};
    vecs[3] = '{data: 8'h00, stop: 1'b0, hold_low_bits: 0,  exp_valid: 1'b0, exp_ferr: 1};
    vecs[4] = '{data: 8'hC3, stop: 1'b1, hold_low_bits: 0,  exp_valid: 1'b1, exp_ferr: 0};

    rstn    = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    clr_i   = 1'b0;
    @(posedge clk100);
    #1;
    ticks(3);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
    rstn = 1'b1;
    ticks(5);

    // Single frames, including framing error and a 40-bit break.
    for (int v = 0; v < 5; v++) begin
      f0 = ferr_cnt;
      v0 = vrise_cnt;
      if (vecs[v].exp_valid) exp_q.push_back(vecs[v].data);
      send_byte(vecs[v].data, vecs[v].stop);
      if (vecs[v].hold_low_bits > 0) begin
        rx_i = 1'b0;
        ticks(vecs[v].hold_low_bits * BIT_T);
        rx_i = 1'b1;
      end
      ticks(2 * BIT_T);
      chk($sformatf("vec%0d_valid", v), {31'd0, valid_o}, {31'd0, vecs[v].exp_valid});
      chk($sformatf("vec%0d_ferr_pulses", v), ferr_cnt - f0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_valid_rises", v), vrise_cnt - v0, {31'd0, vecs[v].exp_valid});
      chk($sformatf("vec%0d_ovr", v), {31'd0, overrun_o}, 32'd0);
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d_data", v), {24'd0, data_o}, {24'd0, vecs[v].data});
        consume($sformatf("vec%0d_released", v));
      end
    end

    // Back-to-back burst with the consumer always ready.
    ready_i = 1'b1;
    h0 = hs_cnt;
    v0 = vrise_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    ticks(2 * BIT_T);
    ready_i = 1'b0;
    chk("burst_handshakes", hs_cnt - h0, 32'd3);
    chk("burst_valid_rises", vrise_cnt - v0, 32'd3);
    chk("burst_sb_empty", exp_q.size(), 32'd0);

    // Overrun: second byte dropped, first kept; clear then drain.
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    ticks(BIT_T);
    chk("ovr_not_yet", {31'd0, overrun_o}, 32'd0);
    send_byte(8'h22, 1'b1);
    ticks(BIT_T);
    chk("ovr_set", {31'd0, overrun_o}, 32'd1);
    chk("ovr_data_kept", {24'd0, data_o}, 32'h11);
    chk("ovr_valid", {31'd0, valid_o}, 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    tick();
    chk("ovr_cleared", {31'd0, overrun_o}, 32'd0);
    consume("ovr_released");

    // Glitch shorter than half a bit.
    f0 = ferr_cnt;
    v0 = vrise_cnt;
    rx_i = 1'b0;
    ticks(4);
    rx_i = 1'b1;
    ticks(2 * BIT_T);
    chk("glitch_no_valid", vrise_cnt - v0, 32'd0);
    chk("glitch_no_ferr", ferr_cnt - f0, 32'd0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    ticks(BIT_T);
    chk("glitch_next_data", {24'd0, data_o}, 32'h81);
    consume("glitch_next_released");

    // Reset mid-frame with a held byte and overrun flag set.
    exp_q.push_back(8'h99);
    send_byte(8'h99, 1'b1);
    ticks(BIT_T);
    send_byte(8'h66, 1'b1);
    ticks(BIT_T);
    chk("pre_rst_ovr", {31'd0, overrun_o}, 32'd1);
    void'(exp_q.pop_back());
    rx_i = 1'b0;
    ticks(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx_i = i[0];
      ticks(BIT_T);
    end
    rx_i = 1'b1;
    ticks(BIT_T / 2);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_data", {24'd0, data_o}, 32'd0);
    chk("midrst_ovr", {31'd0, overrun_o}, 32'd0);
    chk("midrst_ferr", {31'd0, frame_err_o}, 32'd0);
    ticks(3);
    rstn = 1'b1;
    ticks(2 * BIT_T);
    chk("postrst_idle", {31'd0, valid_o}, 32'd0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    ticks(BIT_T);
    chk("postrst_data", {24'd0, data_o}, 32'h7E);
    chk("postrst_valid", {31'd0, valid_o}, 32'd1);
    consume("postrst_released");
    chk("final_sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
